wptr_full_gen: RTL and testbench

Write-side pointer and flag generator for the asynchronous FIFO. It runs entirely in the write clock domain and accepts write requests. It produces the binary RAM write address and the registered Gray-coded write pointer, which the read domain's two-flop synchronizer samples. Using the Gray read pointer already synchronized into the write domain, it derives full, almost-full, occupancy and overflow status.

---
 rtl/wptr_full_gen.sv | 76 +++++++
 tb/tb_wptr_full_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wptr_full_gen.sv
// Write-domain pointer/flag generator for an async FIFO: binary RAM address,
// registered Gray write pointer, and full / almost-full / occupancy / overflow status.
module wptr_full_gen #(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic                 clr_ovf,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wcount,
  output logic                 overflow
);

  localparam logic [ADDR_SIZE:0] AFULL_W = (ADDR_SIZE+1)'(AFULL_THRESH);

  logic [ADDR_SIZE:0] wbin_q, wbin_d;
  logic [ADDR_SIZE:0] wptr_q, wptr_d;
  logic [ADDR_SIZE:0] wcount_q, wcount_d;
  logic [ADDR_SIZE:0] rbin;
  logic               wfull_q, wfull_d;
  logic               wafull_q, wafull_d;
  logic               ovf_q, ovf_d;
  logic               wen;

  always_comb begin
    wen    = winc & ~wfull_q;
    wbin_d = wbin_q + (ADDR_SIZE+1)'(wen);
    wptr_d = (wbin_d >> 1) ^ wbin_d;

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    rbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++)
      rbin[i] = ^(wq2_rptr >> i);

    // Full when the next write pointer is one lap ahead of the read pointer.
    wfull_d  = (wptr_d == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]});
    wcount_d = wbin_d - rbin;
    wafull_d = (wcount_d >= AFULL_W);

    ovf_d = ovf_q;
    if (clr_ovf)        ovf_d = 1'b0;
    if (winc & wfull_q) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wcount_q <= wcount_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_SIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wcount       = wcount_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// Self-checking bench for wptr_full_gen: directed scenarios plus randomized traffic
// compared against an occupancy-based reference model.
module tb_wptr_full_gen;
  localparam int AS    = 4;
  localparam int TH    = 12;
  localparam int DEPTH = 1 << AS;
  localparam int MOD   = 1 << (AS + 1);

  logic          clk = 1'b0;
  logic          rst_n, winc, clr_ovf;
  logic [AS:0]   wq2_rptr;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr, wcount;
  logic          wfull, walmost_full, overflow;

  int n_chk = 0, n_fail = 0;

  // reference state: total writes (mod 2*DEPTH), occupancy and flags
  int m_wbin = 0, m_cnt = 0, m_rb = 0, h1 = 0, h2 = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;
  bit seen_g31 = 0, seen_wrap0 = 0;

  wptr_full_gen #(.ADDR_SIZE(AS), .AFULL_THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wq2_rptr(wq2_rptr), .clr_ovf(clr_ovf),
    .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wcount(wcount), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AS:0] gray(input int b);
    logic [AS:0] v;
    v = AS'(0);
    v = (AS+1)'(b % MOD);
    return v ^ (v >> 1);
  endfunction

  // one clock: drive inputs, advance model, check every output after the edge
  task automatic step(input bit w, input int rb, input bit clr, input bit rst);
    logic [AS:0] prev;
    bit acc;
    winc = w; wq2_rptr = gray(rb); clr_ovf = clr; rst_n = ~rst;
    prev = wptr;
    @(posedge clk);
    acc = 0;
    if (rst) begin
      m_wbin = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      acc = w && !m_full;
      if (w && m_full) m_ovf = 1;
      else if (clr)    m_ovf = 0;
      m_wbin = (m_wbin + int'(acc)) % MOD;
      m_cnt  = (m_wbin - rb + MOD) % MOD;
      m_full = (m_cnt == DEPTH);
      m_af   = (m_cnt >= TH);
    end
    #1;
    chk("waddr",    waddr,        m_wbin % DEPTH);
    chk("wptr",     wptr,         gray(m_wbin));
    chk("wcount",   wcount,       m_cnt);
    chk("wfull",    wfull,        m_full);
    chk("wafull",   walmost_full, m_af);
    chk("overflow", overflow,     m_ovf);
    if (!rst) begin
      chk("wptr_bits_toggled", $countones(prev ^ wptr), acc);
      chk("wcount_le_depth",   wcount <= (AS+1)'(DEPTH), 1);
      chk("full_iff_count",    wfull, wcount == (AS+1)'(DEPTH));
    end
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b1; clr_ovf = 1'b0; wq2_rptr = '0;

    // reset with winc held high, then first write
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("first_waddr", waddr, 1);
    chk("first_wptr",  wptr,  5'b00001);

    // fill to full
    repeat (15) step(1, 0, 0, 0);
    chk("fill_wptr",  wptr,   5'b11000);
    chk("fill_count", wcount, 16);
    chk("fill_full",  wfull,  1);

    // overflow set / clear / set-wins
    repeat (3) step(1, 0, 0, 0);
    chk("ovf_held_waddr", waddr, 0);
    step(0, 0, 1, 0);
    chk("ovf_cleared", overflow, 0);
    step(1, 0, 1, 0);
    chk("ovf_set_wins", overflow, 1);

    // drain release
    step(0, 1, 0, 0);
    chk("release_full",  wfull,  0);
    chk("release_count", wcount, 15);
    step(1, 1, 0, 0);
    chk("refull", wfull, 1);

    // wrap-around with a read side lagging two cycles behind
    step(0, 0, 0, 1);
    h1 = 0; h2 = 0;
    repeat (40) begin
      step(1, h2, 0, 0);
      h2 = h1; h1 = m_wbin;
      if (wptr == 5'b10000) seen_g31 = 1;
      if (seen_g31 && wptr == 5'b00000) seen_wrap0 = 1;
    end
    chk("wrap_saw_g31", seen_g31,   1);
    chk("wrap_saw_0",   seen_wrap0, 1);

    // mid-operation reset
    step(0, 0, 0, 1);
    repeat (7) step(1, 0, 0, 0);
    chk("pre_reset_waddr", waddr, 7);
    step(1, 0, 0, 1);
    chk("midreset_wptr", wptr, 0);
    step(1, 0, 0, 0);
    chk("restart_waddr", waddr, 1);

    // randomized traffic with a lagging, monotonic read pointer
    step(0, 0, 0, 1);
    m_rb = 0; h1 = 0; h2 = 0;
    repeat (600) begin
      bit rst;
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) != 0 && ((h2 - m_rb + MOD) % MOD) != 0)
        m_rb = (m_rb + 1) % MOD;
      step($urandom_range(0, 3) != 0, m_rb, $urandom_range(0, 7) == 0, rst);
      if (rst) begin m_rb = 0; h1 = 0; h2 = 0; end
      else begin h2 = h1; h1 = m_wbin; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
